// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty ramp block and its period timer.
package pwm_pkg;

  localparam int DUTY_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } ramp_state_e;

  function automatic logic [DUTY_W-1:0] clamp_min(
    input logic [DUTY_W-1:0] a,
    input logic [DUTY_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Target-duty command handshake between control logic (master) and the ramp block (slave).
interface pwm_duty_ramp_if
  import pwm_pkg::*;
#(
  parameter int W = DUTY_W
);
  logic [W-1:0] cmd_duty;
  logic         cmd_valid;
  logic         cmd_ready;

  modport master (
    output cmd_duty,
    output cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  cmd_duty,
    input  cmd_valid,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_period_timer.sv
// Free-running period counter; o_tick marks the last cycle of each period (max_duty+1 cycles long).
module pwm_period_timer
  import pwm_pkg::*;
#(
  parameter int W = DUTY_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_max_duty,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;
  logic         w_wrap;

  // >= rather than == so a shrinking max_duty wraps at once instead of running to overflow
  assign w_wrap = (r_cnt >= i_max_duty);
  assign o_tick = w_wrap;

  // counter: wraps to zero after the boundary cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {W{1'b0}};
    end else if (w_wrap) begin
      r_cnt <= {W{1'b0}};
    end else begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slew-rate limiter ahead of the PWM generator: buffers one target command and walks
// duty_val toward it by at most `step` per PWM period.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int DUTY_W = pwm_pkg::DUTY_W
) (
  input  logic              clk,
  input  logic              reset,
  pwm_duty_ramp_if.slave    cmd,
  input  logic [DUTY_W-1:0] max_duty,
  input  logic [DUTY_W-1:0] step,
  output logic [DUTY_W-1:0] duty_val,
  output logic              val_en,
  output logic              at_target,
  output logic              period_tick
);

  logic              w_tick;
  logic              w_accept;
  logic              w_load;
  logic              w_up;
  logic [DUTY_W-1:0] w_new_target;
  logic [DUTY_W-1:0] w_diff;
  logic [DUTY_W-1:0] w_next_duty;

  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] r_target;
  logic [DUTY_W-1:0] r_pend;
  logic              r_pend_valid;
  logic              r_val_en;
  logic              r_period_tick;
  ramp_state_e       r_state;

  pwm_period_timer #(
    .W (DUTY_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_max_duty (max_duty),
    .o_tick     (w_tick)
  );

  assign w_accept = cmd.cmd_valid && !r_pend_valid;
  assign w_load   = w_tick && r_pend_valid;

  // next-duty arithmetic against the target that becomes active on this tick
  always_comb begin
    w_new_target = r_target;
    w_up         = 1'b0;
    w_diff       = {DUTY_W{1'b0}};
    w_next_duty  = r_duty;
    if (w_load) begin
      w_new_target = r_pend;
    end else begin
      w_new_target = r_target;
    end
    // compare first so the subtraction never underflows
    if (w_new_target >= r_duty) begin
      w_up   = 1'b1;
      w_diff = w_new_target - r_duty;
    end else begin
      w_up   = 1'b0;
      w_diff = r_duty - w_new_target;
    end
    if ((step == {DUTY_W{1'b0}}) || (w_diff <= step)) begin
      w_next_duty = w_new_target;
    end else if (w_up) begin
      w_next_duty = r_duty + step;
    end else begin
      w_next_duty = r_duty - step;
    end
  end

  // command buffer, active target, ramp FSM and output strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_duty        <= {DUTY_W{1'b0}};
      r_target      <= {DUTY_W{1'b0}};
      r_pend        <= {DUTY_W{1'b0}};
      r_pend_valid  <= 1'b0;
      r_val_en      <= 1'b0;
      r_period_tick <= 1'b0;
      r_state       <= ST_IDLE;
    end else begin
      r_period_tick <= w_tick;

      // a full buffer holds cmd_ready low, so load and accept never collide
      if (w_load) begin
        r_target     <= r_pend;
        r_pend_valid <= 1'b0;
      end else if (w_accept) begin
        r_pend       <= clamp_min(cmd.cmd_duty, max_duty);
        r_pend_valid <= 1'b1;
      end

      if (w_tick) begin
        r_duty   <= w_next_duty;
        r_val_en <= (w_next_duty != r_duty);
        case (r_state)
          ST_IDLE: begin
            if ((w_new_target != r_duty) && (w_next_duty != w_new_target)) begin
              r_state <= ST_RAMP;
            end
          end
          ST_RAMP: begin
            if (w_next_duty == w_new_target) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end else begin
        r_val_en <= 1'b0;
      end
    end
  end

  assign cmd.cmd_ready = !r_pend_valid;
  assign duty_val      = r_duty;
  assign val_en        = r_val_en;
  assign period_tick   = r_period_tick;
  assign at_target     = (r_state == ST_IDLE) && !r_pend_valid;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: expected duty values are queued with each command
// and popped on every val_en strobe.
module tb_pwm_duty_ramp;
  import pwm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] max_duty;
  logic [31:0] step;
  logic [31:0] duty_val;
  logic        val_en;
  logic        at_target;
  logic        period_tick;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          strobe_cyc = 0;
  int          strobe_cnt = 0;
  logic        prev_val_en = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pwm_duty_ramp_if cmd_if ();

  pwm_duty_ramp dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cmd_if),
    .max_duty    (max_duty),
    .step        (step),
    .duty_val    (duty_val),
    .val_en      (val_en),
    .at_target   (at_target),
    .period_tick (period_tick)
  );

  task automatic step_cycle();
    logic [31:0] e;
    @(negedge clk);
    cyc++;
    if (val_en === 1'b1) begin
      strobe_cnt++;
      strobe_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe duty_val=%0d required=no strobe", duty_val);
      end else begin
        e = exp_q.pop_front();
        if (duty_val !== e) begin
          failures++;
          $display("FAIL strobe_duty duty_val=%0d required=%0d", duty_val, e);
        end
      end
      checks++;
      if (prev_val_en === 1'b1) begin
        failures++;
        $display("FAIL val_en_width val_en high on consecutive cycles, required one-cycle pulse");
      end
    end
    prev_val_en = val_en;
  endtask

  task automatic send_cmd(input logic [31:0] d);
    bit ok = 1'b0;
    cmd_if.cmd_duty  = d;
    cmd_if.cmd_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (cmd_if.cmd_ready === 1'b1) begin
        accept_cyc = cyc;
        @(posedge clk);
        ok = 1'b1;
      end else begin
        step_cycle();
      end
    end
    step_cycle();
    cmd_if.cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout cmd_duty=%0d cmd_ready=%b required accept within 60 cycles", d, cmd_if.cmd_ready);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout remaining=%0d required=0", exp_q.size());
    end
  endtask

  task automatic quiet(input int n);
    int s0 = strobe_cnt;
    repeat (n) step_cycle();
    checks++;
    if (strobe_cnt != s0) begin
      failures++;
      $display("FAIL quiet strobes=%0d required=0", strobe_cnt - s0);
    end
  endtask

  task automatic cycles_to_tick(input string name, input int want);
    int n = 0;
    bit seen = 1'b0;
    while (n < 40 && !seen) begin
      step_cycle();
      n++;
      if (period_tick === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n != want) begin
      failures++;
      $display("FAIL %s cycles=%0d seen=%b required=%0d", name, n, seen, want);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (duty_val !== 32'd0 || val_en !== 1'b0 || period_tick !== 1'b0 ||
        cmd_if.cmd_ready !== 1'b1 || at_target !== 1'b1) begin
      failures++;
      $display("FAIL %s duty=%0d val_en=%b tick=%b ready=%b at_target=%b required 0 0 0 1 1",
               name, duty_val, val_en, period_tick, cmd_if.cmd_ready, at_target);
    end
  endtask

  task automatic check_idle_at(input string name, input logic [31:0] d);
    checks++;
    if (duty_val !== d || at_target !== 1'b1) begin
      failures++;
      $display("FAIL %s duty=%0d at_target=%b required duty=%0d at_target=1", name, duty_val, at_target, d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_duty  = 32'd0;
    max_duty = 32'd9;
    step     = 32'd3;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    reset = 1'b0;
  endtask

  task automatic test_idle();
    cycles_to_tick("first_period_tick", 10);
    cycles_to_tick("period_tick_spacing", 10);
    quiet(15);
    check_idle_at("idle_state", 32'd0);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || strobe_cnt != 0) begin
      failures++;
      $display("FAIL idle_ready ready=%b strobes=%0d required ready=1 strobes=0", cmd_if.cmd_ready, strobe_cnt);
    end
  endtask

  task automatic test_ramp_up();
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd7);
    send_cmd(32'd7);
    checks++;
    if (at_target !== 1'b0) begin
      failures++;
      $display("FAIL ramp_pending_at_target at_target=%b required=0", at_target);
    end
    drain(60);
    step_cycle();
    check_idle_at("ramp_up_done", 32'd7);
  endtask

  task automatic test_clamp_down();
    exp_q.push_back(32'd9);
    send_cmd(32'd50);
    drain(40);
    step_cycle();
    check_idle_at("clamp_done", 32'd9);
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd0);
    send_cmd(32'd0);
    drain(60);
    step_cycle();
    check_idle_at("ramp_down_done", 32'd0);
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd2);
    send_cmd(32'd8);
    checks++;
    if (cmd_if.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL buffer_full_ready cmd_ready=%b required=0", cmd_if.cmd_ready);
    end
    send_cmd(32'd2);
    drain(60);
    step_cycle();
    check_idle_at("reversal_done", 32'd2);
  endtask

  task automatic test_step0();
    int lat;
    exp_q.push_back(32'd0);
    send_cmd(32'd0);
    drain(40);
    step = 32'd0;
    exp_q.push_back(32'd5);
    send_cmd(32'd5);
    drain(40);
    lat = strobe_cyc - accept_cyc - 1;
    checks++;
    if (lat < 2 || lat > 11) begin
      failures++;
      $display("FAIL step0_latency cycles=%0d required 2..11", lat);
    end
    quiet(25);
    check_idle_at("step0_jump", 32'd5);
  endtask

  task automatic test_reset_mid();
    step = 32'd3;
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd0);
    send_cmd(32'd0);
    drain(40);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd6);
    send_cmd(32'd9);
    drain(40);
    send_cmd(32'd1);
    checks++;
    if (duty_val !== 32'd6 || at_target !== 1'b0 || cmd_if.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_state duty=%0d at_target=%b ready=%b required 6 0 0",
               duty_val, at_target, cmd_if.cmd_ready);
    end
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset_mid_ramp");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset_held");
    reset = 1'b0;
    prev_val_en = 1'b0;
    cycles_to_tick("restart_period_tick", 10);
    quiet(25);
    check_idle_at("no_stale_command", 32'd0);
  endtask

  task automatic test_max_zero();
    max_duty = 32'd0;
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      checks++;
      if (period_tick !== 1'b1) begin
        failures++;
        $display("FAIL max0_tick_every_cycle cycle=%0d period_tick=%b required=1", i, period_tick);
      end
    end
    send_cmd(32'd5);
    quiet(6);
    check_idle_at("max0_clamp", 32'd0);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_ramp_up();
    test_clamp_down();
    test_back_to_back();
    test_step0();
    test_reset_mid();
    test_max_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
